// File: rtl/ysyx_22040125_icache_pkg.sv
// rtl/ysyx_22040125_icache_pkg.sv - shared FSM state and line geometry for the instruction cache
package ysyx_22040125_icache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REFILL0,
      REFILL1,
      RESP
   } icache_state_t;

   localparam int LINE_BYTES = 8;
   localparam int WORD_BYTES = 4;
   localparam int OFFSET_W   = 3;

endpackage

// File: rtl/ysyx_22040125_icache_array.sv
// rtl/ysyx_22040125_icache_array.sv - tag/data/valid storage, combinational read, one write port
module ysyx_22040125_icache_array
   import ysyx_22040125_icache_pkg::*;
#(
   parameter int NLINES = 64,
   parameter int IDXW   = $clog2(NLINES),
   parameter int TAGW   = 32 - OFFSET_W - IDXW
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [IDXW-1:0] rd_idx,
   output logic            rd_valid,
   output logic [TAGW-1:0] rd_tag,
   output logic [31:0]     rd_word0,
   output logic [31:0]     rd_word1,
   input  logic [IDXW-1:0] wr_idx,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [31:0]     wr_data,
   input  logic            commit,
   input  logic            commit_valid,
   input  logic [TAGW-1:0] commit_tag
);

   logic [NLINES-1:0] valid;
   logic [TAGW-1:0]   tags  [NLINES];
   logic [31:0]       word0 [NLINES];
   logic [31:0]       word1 [NLINES];

   // Clearing wins over a same-cycle commit so a flush can never be lost.
   always_ff @(posedge clk) begin
      if (rst || flush)
         valid <= '0;
      else if (commit && commit_valid)
         valid[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_sel)
            word1[wr_idx] <= wr_data;
         else
            word0[wr_idx] <= wr_data;
      end
      if (commit)
         tags[wr_idx] <= commit_tag;
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_word0 = word0[rd_idx];
   assign rd_word1 = word1[rd_idx];

endmodule

// File: rtl/ysyx_22040125_icache.sv
// rtl/ysyx_22040125_icache.sv - direct-mapped I-cache with 2-word line refill; ICACHE_PERF_EN adds hit/miss counters
module ysyx_22040125_icache
   import ysyx_22040125_icache_pkg::*;
#(
   parameter int NLINES = 64,
   parameter int ADDR_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_r_en,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [31:0]       inst_r,
   output logic              inst_r_valid,
   input  logic              flush,
   output logic              mem_r_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_r,
   input  logic              mem_r_valid
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int IDXW = $clog2(NLINES);
   localparam int TAGW = ADDR_W - OFFSET_W - IDXW;

   icache_state_t     state, state_n;
   logic [ADDR_W-1:0] req_addr;
   logic              flush_pend;
   logic [IDXW-1:0]   rd_idx;
   logic              rd_valid;
   logic [TAGW-1:0]   rd_tag;
   logic [31:0]       rd_word0, rd_word1;
   logic              hit;
   logic              wr_en, wr_sel, commit;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{inst_addr[1:0], req_addr[1:0]};

   // Lookups use the live address in IDLE and the latched one while refilling.
   assign rd_idx = (state == IDLE) ? inst_addr[OFFSET_W+IDXW-1:OFFSET_W]
                                   : req_addr[OFFSET_W+IDXW-1:OFFSET_W];
   assign hit = rd_valid && !flush && (rd_tag == inst_addr[ADDR_W-1:OFFSET_W+IDXW]);

   ysyx_22040125_icache_array #(
      .NLINES (NLINES),
      .IDXW   (IDXW),
      .TAGW   (TAGW)
   ) u_array (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .rd_idx       (rd_idx),
      .rd_valid     (rd_valid),
      .rd_tag       (rd_tag),
      .rd_word0     (rd_word0),
      .rd_word1     (rd_word1),
      .wr_idx       (req_addr[OFFSET_W+IDXW-1:OFFSET_W]),
      .wr_en        (wr_en),
      .wr_sel       (wr_sel),
      .wr_data      (mem_r),
      .commit       (commit),
      .commit_valid (!(flush_pend || flush)),
      .commit_tag   (req_addr[ADDR_W-1:OFFSET_W+IDXW])
   );

   always_comb begin
      state_n      = state;
      mem_r_en     = 1'b0;
      mem_addr     = '0;
      inst_r_valid = 1'b0;
      wr_en        = 1'b0;
      wr_sel       = 1'b0;
      commit       = 1'b0;
      case (state)
         IDLE: begin
            if (inst_r_en)
               state_n = hit ? RESP : REFILL0;
         end
         REFILL0: begin
            mem_r_en = 1'b1;
            mem_addr = {req_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
            if (mem_r_valid) begin
               wr_en   = 1'b1;
               state_n = REFILL1;
            end
         end
         REFILL1: begin
            mem_r_en = 1'b1;
            mem_addr = {req_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(WORD_BYTES)};
            if (mem_r_valid) begin
               wr_en   = 1'b1;
               wr_sel  = 1'b1;
               commit  = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            inst_r_valid = 1'b1;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         inst_r     <= '0;
         flush_pend <= 1'b0;
`ifdef ICACHE_PERF_EN
         hit_cnt    <= '0;
         miss_cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         if (state == IDLE && inst_r_en) begin
            req_addr <= inst_addr;
            if (hit)
               inst_r <= inst_addr[2] ? rd_word1 : rd_word0;
`ifdef ICACHE_PERF_EN
            if (hit)
               hit_cnt <= hit_cnt + 32'd1;
            else
               miss_cnt <= miss_cnt + 32'd1;
`endif
         end
         // Word 0 is already stored; word 1 is still on the bus this cycle.
         if (state == REFILL1 && mem_r_valid)
            inst_r <= req_addr[2] ? mem_r : rd_word0;
         if (state == RESP)
            flush_pend <= 1'b0;
         else if (flush && (state == REFILL0 || state == REFILL1))
            flush_pend <= 1'b1;
      end
   end

   // The CPU must hold the fetch address steady while a refill is in flight.
   assert property (@(posedge clk) disable iff (rst)
      (inst_r_en && (state == REFILL0 || state == REFILL1)) |-> (inst_addr == req_addr));

endmodule

// File: tb/tb_ysyx_22040125_icache.sv
// tb/tb_ysyx_22040125_icache.sv - directed vector bench for the instruction cache
module tb_ysyx_22040125_icache;

   logic        clk = 1'b0;
   logic        rst, inst_r_en, flush, mem_r_valid;
   logic [31:0] inst_addr, mem_r;
   logic [31:0] inst_r, mem_addr;
   logic        inst_r_valid, mem_r_en;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ysyx_22040125_icache dut (
      .clk          (clk),
      .rst          (rst),
      .inst_r_en    (inst_r_en),
      .inst_addr    (inst_addr),
      .inst_r       (inst_r),
      .inst_r_valid (inst_r_valid),
      .flush        (flush),
      .mem_r_en     (mem_r_en),
      .mem_addr     (mem_addr),
      .mem_r        (mem_r),
      .mem_r_valid  (mem_r_valid)
`ifdef ICACHE_PERF_EN
      ,
      .hit_cnt      (hit_cnt),
      .miss_cnt     (miss_cnt)
`endif
   );

   // fmode: 0 plain, 1 flush pulse in IDLE before the request, 2 flush during REFILL1
   typedef struct {
      logic [31:0] addr;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] exp_data;
      int          fmode;
      int          exp_mem;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                        input int fmode, output logic [31:0] data, output int nmem, output int lat);
      logic [31:0] line;
      line = {a[31:3], 3'b000};
      data = '0;
      nmem = 0;
      lat  = -1;
      if (fmode == 1) begin
         @(negedge clk); flush = 1'b1;
         @(negedge clk); flush = 1'b0;
      end
      @(negedge clk);
      inst_r_en = 1'b1;
      inst_addr = a;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(negedge clk);
         flush       = 1'b0;
         mem_r_valid = 1'b0;
         if (inst_r_valid) begin
            data      = inst_r;
            lat       = c;
            inst_r_en = 1'b0;
         end else if (mem_r_en) begin
            if (mem_addr == line + 32'(nmem * 4)) nmem++;
            else nmem += 10;
            mem_r_valid = 1'b1;
            mem_r       = mem_addr[2] ? w1 : w0;
            if (fmode == 2 && mem_addr[2]) flush = 1'b1;
         end
      end
      inst_r_en   = 1'b0;
      mem_r_valid = 1'b0;
      flush       = 1'b0;
   endtask

   initial begin
      logic [31:0] data;
      int          nmem, lat;
      logic        seen;

      vecs[0]  = '{32'h8000_0000, 32'h0000_0413, 32'h0000_0493, 32'h0000_0413, 0, 2};
      vecs[1]  = '{32'h8000_0004, 32'h0000_0413, 32'h0000_0493, 32'h0000_0493, 0, 0};
      vecs[2]  = '{32'h8000_0200, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 0, 2};
      vecs[3]  = '{32'h8000_0000, 32'h0000_0413, 32'h0000_0493, 32'h0000_0413, 0, 2};
      vecs[4]  = '{32'h8000_0004, 32'h0000_0413, 32'h0000_0493, 32'h0000_0493, 0, 0};
      vecs[5]  = '{32'h8000_0000, 32'h0000_0413, 32'h0000_0493, 32'h0000_0413, 1, 2};
      vecs[6]  = '{32'h8000_000C, 32'h3333_0001, 32'h3333_0002, 32'h3333_0002, 0, 2};
      vecs[7]  = '{32'h8000_0008, 32'h3333_0001, 32'h3333_0002, 32'h3333_0001, 0, 0};
      vecs[8]  = '{32'h8000_01FC, 32'h4444_0000, 32'h4444_0004, 32'h4444_0004, 0, 2};
      vecs[9]  = '{32'h8000_01F8, 32'h4444_0000, 32'h4444_0004, 32'h4444_0000, 0, 0};
      vecs[10] = '{32'h8000_000C, 32'h3333_0001, 32'h3333_0002, 32'h3333_0002, 0, 0};
      vecs[11] = '{32'h8000_0004, 32'h0000_0413, 32'h0000_0493, 32'h0000_0493, 0, 0};
      vecs[12] = '{32'h8000_0010, 32'h5555_0000, 32'h5555_0004, 32'h5555_0000, 2, 2};
      vecs[13] = '{32'h8000_0010, 32'h5555_0000, 32'h5555_0004, 32'h5555_0000, 0, 2};
      vecs[14] = '{32'h8000_0014, 32'h5555_0000, 32'h5555_0004, 32'h5555_0004, 0, 0};

      rst = 1'b1; inst_r_en = 1'b0; inst_addr = '0; flush = 1'b0;
      mem_r_valid = 1'b0; mem_r = '0;
      repeat (3) @(negedge clk);
      check("reset inst_r_valid", 32'(inst_r_valid), 32'd0);
      check("reset inst_r", inst_r, 32'd0);
      check("reset mem_r_en", 32'(mem_r_en), 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         fetch(vecs[i].addr, vecs[i].w0, vecs[i].w1, vecs[i].fmode, data, nmem, lat);
         check($sformatf("v%0d responded", i), 32'(lat > 0), 32'd1);
         check($sformatf("v%0d inst_r", i), data, vecs[i].exp_data);
         check($sformatf("v%0d mem fetches", i), 32'(nmem), 32'(vecs[i].exp_mem));
         if (vecs[i].exp_mem == 0)
            check($sformatf("v%0d hit latency", i), 32'(lat), 32'd1);
         @(negedge clk);
         check($sformatf("v%0d single pulse", i), 32'(inst_r_valid), 32'd0);
         check($sformatf("v%0d mem_r_en idle", i), 32'(mem_r_en), 32'd0);
      end

      // Reset in the middle of a refill, followed by a stale downstream response.
      @(negedge clk);
      inst_r_en = 1'b1;
      inst_addr = 32'h8000_0018;
      @(negedge clk);
      check("midrst mem_r_en before", 32'(mem_r_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      inst_r_en = 1'b0;
      check("midrst mem_r_en after", 32'(mem_r_en), 32'd0);
      mem_r_valid = 1'b1;
      mem_r = 32'hDEAD_BEEF;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         mem_r_valid = 1'b0;
         if (inst_r_valid || mem_r_en) seen = 1'b1;
      end
      check("midrst no response", 32'(seen), 32'd0);
      fetch(32'h8000_0018, 32'h6666_0000, 32'h6666_0004, 0, data, nmem, lat);
      check("midrst refetch inst_r", data, 32'h6666_0000);
      check("midrst refetch mem fetches", 32'(nmem), 32'd2);

`ifdef ICACHE_PERF_EN
      begin
         logic [31:0] paddr [8];
         paddr = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0000,
                   32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0014};
         @(negedge clk); rst = 1'b1;
         @(negedge clk); rst = 1'b0;
         for (int i = 0; i < 8; i++)
            fetch(paddr[i], 32'h0, 32'h0, 0, data, nmem, lat);
         @(negedge clk);
         check("perf miss_cnt", miss_cnt, 32'd3);
         check("perf hit_cnt", hit_cnt, 32'd5);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("perf miss_cnt reset", miss_cnt, 32'd0);
         check("perf hit_cnt reset", hit_cnt, 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
